watch_set_ctrl: RTL and testbench

Time-set controller for the ASIC watch. It debounces the MODE and ADJ push buttons, then sequences the hour and minute counters through RUN, SET_HH and SET_MM. It emits single-cycle increment pulses, including auto-repeat while ADJ is held. It also gates the time base, clears seconds on exit from set mode, and drives digit blanking for the 7-segment drivers. It sits between the raw board buttons and the count24h/minute counters, in the fast scan-clock domain.

---
 rtl/watch_set_ctrl_if.sv | 22 ++
 rtl/watch_set_ctrl.sv | 173 +++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/watch_set_ctrl_if.sv
// Button inputs and set-mode control outputs of the watch time-set controller.
interface watch_set_ctrl_if;
  logic       mode_btn_i;
  logic       adj_btn_i;
  logic       run_en_o;
  logic       inc_h_o;
  logic       inc_m_o;
  logic       clr_sec_o;
  logic       blank_h_o;
  logic       blank_m_o;
  logic [1:0] state_o;

  modport master (
    output mode_btn_i, adj_btn_i,
    input  run_en_o, inc_h_o, inc_m_o, clr_sec_o, blank_h_o, blank_m_o, state_o
  );

  modport slave (
    input  mode_btn_i, adj_btn_i,
    output run_en_o, inc_h_o, inc_m_o, clr_sec_o, blank_h_o, blank_m_o, state_o
  );
endinterface

// File: rtl/watch_set_ctrl.sv
// Watch time-set controller: debounces MODE/ADJ, steps RUN -> SET_HH -> SET_MM,
// and drives hour/minute increments, seconds clear and digit blanking.
module watch_set_ctrl #(
  parameter int unsigned DEB_CYC   = 20,
  parameter int unsigned LP_CYC    = 1000,
  parameter int unsigned RPT_CYC   = 250,
  parameter int unsigned BLINK_CYC = 500,
  parameter int unsigned TOUT_CYC  = 30000
) (
  input logic             clk_i,
  input logic             rstn_i,
  watch_set_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    SET_HH = 2'b01,
    SET_MM = 2'b10
  } state_e;

  localparam int MODE = 0;
  localparam int ADJ  = 1;

  state_e           state_q, state_d;
  logic [1:0]       sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [1:0][15:0] deb_cnt_q;
  logic             mode_press, adj_press, in_set, both_low, tout;
  logic [15:0]      idle_cnt_q, rpt_cnt_q, blink_cnt_q;
  logic [16:0]      rpt_next;
  logic             rpt_armed_q, rpt_first_done_q, rpt_hit;
  logic             inc_h_d, inc_m_d, clr_sec_d, blink_force;
  logic             inc_h_q, inc_m_q, clr_sec_q, run_en_q, phase_q;

  // Two-flop synchroniser, then a per-button stability counter that must see
  // DEB_CYC consecutive disagreeing samples before the debounced level flips.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      deb_cnt_q  <= '0;
    end else begin
      sync1_q    <= {bus.adj_btn_i, bus.mode_btn_i};
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == 16'(DEB_CYC - 1)) begin
          deb_q[i]     <= ~deb_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign mode_press = deb_q[MODE] & ~deb_prev_q[MODE];
  assign adj_press  = deb_q[ADJ] & ~deb_prev_q[ADJ];
  assign in_set     = (state_q != RUN);
  assign both_low   = ~|deb_q;
  assign tout       = in_set & both_low & (idle_cnt_q == 16'(TOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      idle_cnt_q <= '0;
    end else if (!in_set || mode_press || adj_press || tout) begin
      idle_cnt_q <= '0;
    end else if (both_low) begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end

  // Repeat counter: after a press it counts toward LP_CYC, after the first
  // repeat it restarts and counts toward RPT_CYC; any MODE press or release disarms.
  assign rpt_next = {1'b0, rpt_cnt_q} + 17'd1;
  assign rpt_hit  = rpt_armed_q & deb_q[ADJ] & in_set &
                    (rpt_next >= (rpt_first_done_q ? 17'(RPT_CYC) : 17'(LP_CYC)));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rpt_armed_q      <= 1'b0;
      rpt_first_done_q <= 1'b0;
      rpt_cnt_q        <= '0;
    end else if (mode_press || !in_set || !deb_q[ADJ]) begin
      rpt_armed_q      <= 1'b0;
      rpt_first_done_q <= 1'b0;
      rpt_cnt_q        <= '0;
    end else if (adj_press) begin
      rpt_armed_q      <= 1'b1;
      rpt_first_done_q <= 1'b0;
      rpt_cnt_q        <= 16'd1;
    end else if (rpt_hit) begin
      rpt_first_done_q <= 1'b1;
      rpt_cnt_q        <= '0;
    end else if (rpt_armed_q) begin
      rpt_cnt_q        <= rpt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        RUN:     state_d = SET_HH;
        SET_HH:  state_d = SET_MM;
        default: state_d = RUN;
      endcase
    end else if (tout) begin
      state_d = RUN;
    end
  end

  // A MODE press in the same cycle swallows any ADJ activity.
  always_comb begin
    inc_h_d = 1'b0;
    inc_m_d = 1'b0;
    if (!mode_press && (adj_press || rpt_hit)) begin
      inc_h_d = (state_q == SET_HH);
      inc_m_d = (state_q == SET_MM);
    end
    clr_sec_d   = in_set && (state_d == RUN);
    blink_force = (state_d != state_q) || inc_h_d || inc_m_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      inc_h_q   <= 1'b0;
      inc_m_q   <= 1'b0;
      clr_sec_q <= 1'b0;
      run_en_q  <= 1'b1;
    end else begin
      inc_h_q   <= inc_h_d;
      inc_m_q   <= inc_m_d;
      clr_sec_q <= clr_sec_d;
      run_en_q  <= (state_d == RUN);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      phase_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else if (blink_force) begin
      phase_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else if (blink_cnt_q == 16'(BLINK_CYC - 1)) begin
      phase_q     <= ~phase_q;
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_q + 16'd1;
    end
  end

  assign bus.run_en_o  = run_en_q;
  assign bus.inc_h_o   = inc_h_q;
  assign bus.inc_m_o   = inc_m_q;
  assign bus.clr_sec_o = clr_sec_q;
  assign bus.blank_h_o = (state_q == SET_HH) & ~phase_q;
  assign bus.blank_m_o = (state_q == SET_MM) & ~phase_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl: expected pulses go to a scoreboard queue
// that a negedge monitor drains; level outputs are checked at chosen cycles.
module tb_watch_set_ctrl;
  localparam int DEB   = 4;
  localparam int LP    = 20;
  localparam int RPT   = 5;
  localparam int BLINK = 8;
  localparam int TOUT  = 100;

  localparam logic [2:0] K_INC_H = 3'b100;
  localparam logic [2:0] K_INC_M = 3'b010;
  localparam logic [2:0] K_CLR   = 3'b001;

  typedef struct {
    int         at;
    logic [2:0] kind;
    logic [1:0] st;
    logic       run;
  } exp_t;

  logic clk_i = 1'b0;
  logic rstn_i;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [2:0] mon_got;

  watch_set_ctrl_if bus ();

  watch_set_ctrl #(
    .DEB_CYC  (DEB),
    .LP_CYC   (LP),
    .RPT_CYC  (RPT),
    .BLINK_CYC(BLINK),
    .TOUT_CYC (TOUT)
  ) dut (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Every pulse the DUT emits must match the oldest scoreboard entry exactly.
  always @(negedge clk_i) begin
    mon_got = {bus.inc_h_o, bus.inc_m_o, bus.clr_sec_o};
    if (mon_got != 3'b000) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL pulse_unexpected: cycle=%0d got kind=%b state=%b, required no pulse",
                 cyc, mon_got, bus.state_o);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.at != cyc || mon_e.kind !== mon_got ||
            mon_e.st !== bus.state_o || mon_e.run !== bus.run_en_o) begin
          errors++;
          $display("[TB] FAIL pulse: got cycle=%0d kind=%b state=%b run=%b, required cycle=%0d kind=%b state=%b run=%b",
                   cyc, mon_got, bus.state_o, bus.run_en_o, mon_e.at, mon_e.kind, mon_e.st, mon_e.run);
        end
      end
    end
  end

  task automatic expectPulse(input int at, input logic [2:0] kind, input logic [1:0] st,
                             input logic run);
    exp_t e;
    e.at   = at;
    e.kind = kind;
    e.st   = st;
    e.run  = run;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input logic mode, input logic adj, input int n);
    bus.mode_btn_i = mode;
    bus.adj_btn_i  = adj;
    repeat (n) @(negedge clk_i);
  endtask

  // Vector order: state_o[1:0], run_en, inc_h, inc_m, clr_sec, blank_h, blank_m
  task automatic checkOutput(input string name, input logic [7:0] expv);
    logic [7:0] got;
    got = {bus.state_o, bus.run_en_o, bus.inc_h_o, bus.inc_m_o, bus.clr_sec_o,
           bus.blank_h_o, bus.blank_m_o};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: cycle=%0d got %b, required %b", name, cyc, got, expv);
    end
  endtask

  initial begin
    int p;
    int s0;
    int rpt_at[4];
    logic bh;
    rpt_at = '{20, 25, 30, 35};

    rstn_i         = 1'b0;
    bus.mode_btn_i = 1'b0;
    bus.adj_btn_i  = 1'b0;
    @(negedge clk_i);
    applyStimulus(0, 0, 2);
    checkOutput("reset_state", 8'b00_1_000_00);
    rstn_i = 1'b1;
    applyStimulus(0, 0, 50);
    checkOutput("idle_run", 8'b00_1_000_00);

    $display("[TB] MODE glitch and clean press");
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 15);
    checkOutput("glitch_ignored", 8'b00_1_000_00);
    applyStimulus(1, 0, 6);
    checkOutput("mode_before_latency", 8'b00_1_000_00);
    applyStimulus(1, 0, 1);
    checkOutput("mode_to_set_hh", 8'b01_0_000_00);
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 12);

    $display("[TB] ADJ hold in SET_HH");
    p = cyc + 6;
    expectPulse(p + 1, K_INC_H, 2'b01, 1'b0);
    for (int k = 0; k < 4; k++) expectPulse(p + rpt_at[k], K_INC_H, 2'b01, 1'b0);
    applyStimulus(0, 1, 38);
    applyStimulus(0, 0, 15);

    $display("[TB] SET_MM single step and exit");
    applyStimulus(1, 0, 6);
    applyStimulus(0, 0, 10);
    checkOutput("in_set_mm_blanked", 8'b10_0_000_01);
    p = cyc + 6;
    expectPulse(p + 1, K_INC_M, 2'b10, 1'b0);
    applyStimulus(0, 1, 6);
    applyStimulus(0, 0, 10);
    p = cyc + 6;
    expectPulse(p + 1, K_CLR, 2'b00, 1'b1);
    applyStimulus(1, 0, 6);
    applyStimulus(0, 0, 3);
    checkOutput("exit_to_run", 8'b00_1_000_00);
    applyStimulus(0, 0, 10);

    $display("[TB] SET_HH blink and timeout");
    s0 = cyc;
    expectPulse(s0 + 112, K_CLR, 2'b00, 1'b1);
    applyStimulus(1, 0, 6);
    applyStimulus(0, 0, 1);
    for (int k = 0; k < 32; k++) begin
      bh = ((k / 8) % 2) == 1;
      checkOutput($sformatf("blink_h_%0d", k), {2'b01, 1'b0, 3'b000, bh, 1'b0});
      applyStimulus(0, 0, 1);
    end
    applyStimulus(0, 0, 80);
    checkOutput("timeout_run", 8'b00_1_000_00);

    $display("[TB] simultaneous press and reset mid-repeat");
    applyStimulus(1, 0, 6);
    applyStimulus(0, 0, 10);
    applyStimulus(1, 1, 6);
    applyStimulus(0, 1, 2);
    checkOutput("simul_press_set_mm", 8'b10_0_000_00);
    applyStimulus(0, 1, 25);
    applyStimulus(0, 0, 10);
    p = cyc + 6;
    expectPulse(p + 1, K_INC_M, 2'b10, 1'b0);
    expectPulse(p + 20, K_INC_M, 2'b10, 1'b0);
    expectPulse(p + 25, K_INC_M, 2'b10, 1'b0);
    applyStimulus(0, 1, 33);
    rstn_i = 1'b0;
    applyStimulus(0, 0, 1);
    checkOutput("reset_mid_repeat", 8'b00_1_000_00);
    applyStimulus(0, 0, 2);
    rstn_i = 1'b1;
    applyStimulus(0, 0, 20);
    checkOutput("after_reset_idle", 8'b00_1_000_00);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL pulses_missing: got %0d outstanding, required 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
